// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the common data bus: widths, the invalid ROB tag
// and the broadcast lane record snooped by every reservation station and the ROB.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;

  // Tag value meaning "no ROB entry"; an idle broadcast lane always shows it.
  localparam logic [ROB_TAG_W-1:0] INVALID_ROB = 6'b010000;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      data;
  } cdb_lane_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bundle: per-producer result request/ready plus the two
// registered broadcast lanes.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int TAG_W   = cpu_pkg::ROB_TAG_W
);

  // Handshake: producer i raises req_valid[i] with req_data/req_rob slice i and
  // holds them stable until req_ready[i]; the transfer happens on the rising
  // clock edge where valid&ready. Dropping valid without ready is legal (squash).
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*XLEN-1:0]  req_data;
  logic [NUM_REQ*TAG_W-1:0] req_rob;
  logic [NUM_REQ-1:0]       req_ready;

  logic                     iscast;
  logic [XLEN-1:0]          cdbdata;
  logic [TAG_W-1:0]         robNum;
  logic                     iscast2;
  logic [XLEN-1:0]          cdbdata2;
  logic [TAG_W-1:0]         robNum2;

  modport master (
    output req_valid, req_data, req_rob,
    input  req_ready, iscast, cdbdata, robNum, iscast2, cdbdata2, robNum2
  );

  modport slave (
    input  req_valid, req_data, req_rob,
    output req_ready, iscast, cdbdata, robNum, iscast2, cdbdata2, robNum2
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational two-grant round-robin picker: the first two valid indices found
// scanning upward from ptr (with wrap) get gnt0 and gnt1 respectively.
module rr_pick2 #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt0,
  output logic [NUM_REQ-1:0] gnt1,
  output logic               any0,
  output logic               any1,
  output logic [PTR_W-1:0]   last_idx
);

  int idx;

  always_comb begin
    gnt0     = '0;
    gnt1     = '0;
    any0     = 1'b0;
    any1     = 1'b0;
    last_idx = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) begin
        if (!any0) begin
          gnt0[idx] = 1'b1;
          any0      = 1'b1;
          last_idx  = PTR_W'(idx);
        end else if (!any1) begin
          gnt1[idx] = 1'b1;
          any1      = 1'b1;
          last_idx  = PTR_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane CDB arbiter: round-robin grants to up to two producers per cycle and
// registered broadcasts. Define CDB_PERF_CNT_EN for per-requester stall counters.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int TAG_W   = cpu_pkg::ROB_TAG_W
`ifdef CDB_PERF_CNT_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  cdb_arbiter_if.slave      bus
`ifdef CDB_PERF_CNT_EN
  , output logic [NUM_REQ*PERF_W-1:0] perf_stall_cnt
`endif
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [TAG_W-1:0] INV_TAG = TAG_W'(INVALID_ROB);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   last_idx;
  logic [NUM_REQ-1:0] gnt0;
  logic [NUM_REQ-1:0] gnt1;
  logic               any0;
  logic               any1;
  logic [XLEN-1:0]    data0;
  logic [XLEN-1:0]    data1;
  logic [TAG_W-1:0]   tag0;
  logic [TAG_W-1:0]   tag1;

  rr_pick2 #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .valid    (bus.req_valid),
    .ptr      (rr_ptr),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .any0     (any0),
    .any1     (any1),
    .last_idx (last_idx)
  );

  // Nothing is accepted while reset is held or during a flush.
  assign bus.req_ready = (reset && !flush) ? (gnt0 | gnt1) : '0;

  assign ptr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;

  always_comb begin
    data0 = '0;
    tag0  = '0;
    data1 = '0;
    tag1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt0[i]) begin
        data0 = bus.req_data[i*XLEN +: XLEN];
        tag0  = bus.req_rob[i*TAG_W +: TAG_W];
      end
      if (gnt1[i]) begin
        data1 = bus.req_data[i*XLEN +: XLEN];
        tag1  = bus.req_rob[i*TAG_W +: TAG_W];
      end
    end
  end

  // Lane data holds its last broadcast value when idle; only valid/tag go quiet.
  // An accepted INVALID_ROB result is swallowed and its lane stays idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.iscast   <= 1'b0;
      bus.cdbdata  <= '0;
      bus.robNum   <= INV_TAG;
      bus.iscast2  <= 1'b0;
      bus.cdbdata2 <= '0;
      bus.robNum2  <= INV_TAG;
      rr_ptr       <= '0;
    end else begin
      bus.iscast  <= 1'b0;
      bus.robNum  <= INV_TAG;
      bus.iscast2 <= 1'b0;
      bus.robNum2 <= INV_TAG;
      if (!flush) begin
        if (any0 && tag0 != INV_TAG) begin
          bus.iscast  <= 1'b1;
          bus.robNum  <= tag0;
          bus.cdbdata <= data0;
        end
        if (any1 && tag1 != INV_TAG) begin
          bus.iscast2  <= 1'b1;
          bus.robNum2  <= tag1;
          bus.cdbdata2 <= data1;
        end
        if (any0) begin
          rr_ptr <= ptr_next;
        end
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [NUM_REQ-1:0][PERF_W-1:0] stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && !bus.req_ready[i] && stall_cnt[i] != {PERF_W{1'b1}}) begin
          stall_cnt[i] <= stall_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign perf_stall_cnt = stall_cnt;
`endif

endmodule
